// File: rtl/dcm_ramp_controller_if.sv
// Command and DCM-programming bundle for dcm_ramp_controller.
// master = upstream command source plus DCM side, slave = the controller.
interface dcm_ramp_controller_if #(
  parameter int NUM_CH = 4,
  parameter int CHAN_W = 2
);
  logic                cmd_valid;
  logic [CHAN_W-1:0]   cmd_chan;
  logic [7:0]          cmd_mult;
  logic [NUM_CH-1:0]   prog_en;
  logic                prog_data;
  logic [NUM_CH-1:0]   prog_done;
  logic                busy;
  logic [NUM_CH*8-1:0] cur_mult;
  logic [NUM_CH-1:0]   err_timeout;

  modport master (
    output cmd_valid, cmd_chan, cmd_mult, prog_done,
    input  prog_en, prog_data, busy, cur_mult, err_timeout
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_mult, prog_done,
    output prog_en, prog_data, busy, cur_mult, err_timeout
  );
endinterface

// File: rtl/dcm_ramp_controller.sv
// Multi-channel DCM_CLKGEN reprogrammer: ramps each channel's multiplier toward its
// target in bounded steps, one serial PROG frame per step, channels served round-robin.
module dcm_ramp_controller #(
  parameter int NUM_CH         = 4,
  parameter int CHAN_W         = 2,
  parameter int MIN_MULT       = 2,
  parameter int MAX_MULT       = 88,
  parameter int INIT_MULT      = 60,
  parameter int DIVIDER        = 8,
  parameter int STEP           = 4,
  parameter int DWELL_CYCLES   = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dcm_ramp_controller_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] D_M1 = 8'(DIVIDER - 1);

  typedef enum logic [3:0] {
    IDLE, ARB, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, DWELL
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        target [NUM_CH];
  logic [7:0]        cur [NUM_CH];
  logic [NUM_CH-1:0] err;
  logic [SEL_W-1:0]  ch, last_ch, pick;
  logic [7:0]        step_m, pick_tgt, pick_cur;
  logic [3:0]        bcnt;
  logic [DW_W-1:0]   dcnt;
  logic [TO_W-1:0]   tcnt;
  logic [CHAN_W-1:0] cmd_chan;
  logic [7:0]        d_shift, m_shift;
  logic              any_need, done_sel, timeout_hit, en_bit, data_bit;
  int                idx;

  function automatic logic [7:0] clamp_mult(input logic [7:0] m);
    if (m < 8'(MIN_MULT)) return 8'(MIN_MULT);
    if (m > 8'(MAX_MULT)) return 8'(MAX_MULT);
    return m;
  endfunction

  // An unknown current value (0) jumps straight to the target instead of ramping.
  function automatic logic [7:0] step_mult(input logic [7:0] tgt, input logic [7:0] c);
    logic [7:0] diff;
    if (c == 8'd0) return tgt;
    if (tgt > c) begin
      diff = tgt - c;
      return (diff > 8'(STEP)) ? c + 8'(STEP) : tgt;
    end
    diff = c - tgt;
    return (diff > 8'(STEP)) ? c - 8'(STEP) : tgt;
  endfunction

  assign cmd_chan = bus.cmd_chan;
  assign d_shift  = D_M1 >> (bcnt - 4'd2);
  assign m_shift  = (step_m - 8'd1) >> (bcnt - 4'd2);

  always_comb begin
    any_need = 1'b0;
    pick     = last_ch;
    pick_tgt = 8'd0;
    pick_cur = 8'd0;
    idx      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(last_ch) + 1 + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!any_need && (target[idx] != cur[idx])) begin
        any_need = 1'b1;
        pick     = SEL_W'(idx);
        pick_tgt = target[idx];
        pick_cur = cur[idx];
      end
    end
  end

  always_comb begin
    done_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(ch) == c) done_sel = bus.prog_done[c];
  end

  // tcnt + 1 is the number of cycles since the GO edge at the edge that evaluates it.
  assign timeout_hit = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    en_bit    = 1'b0;
    data_bit  = 1'b0;
    case (state)
      IDLE:      if (any_need) state_nxt = ARB;
      ARB:       state_nxt = any_need ? LOAD_D : IDLE;
      LOAD_D: begin
        en_bit   = 1'b1;
        data_bit = (bcnt == 4'd0) ? 1'b1 : (bcnt == 4'd1) ? 1'b0 : d_shift[0];
        if (bcnt == 4'd9) state_nxt = GAP1;
      end
      GAP1:      if (bcnt == 4'd2) state_nxt = LOAD_M;
      LOAD_M: begin
        en_bit   = 1'b1;
        data_bit = (bcnt < 4'd2) ? 1'b1 : m_shift[0];
        if (bcnt == 4'd9) state_nxt = GAP2;
      end
      GAP2:      if (bcnt == 4'd1) state_nxt = GO;
      GO: begin
        en_bit    = 1'b1;
        state_nxt = WAIT_DONE;
      end
      WAIT_DONE: if (done_sel || timeout_hit) state_nxt = DWELL;
      DWELL:     if (dcnt == DW_W'(DWELL_CYCLES - 1)) state_nxt = ARB;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.prog_en  = '0;
    bus.cur_mult = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.prog_en[c]        = en_bit && (int'(ch) == c);
      bus.cur_mult[c*8 +: 8] = cur[c];
    end
  end

  assign bus.prog_data   = data_bit;
  assign bus.busy        = (state != IDLE);
  assign bus.err_timeout = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt    <= '0;
      dcnt    <= '0;
      tcnt    <= '0;
      ch      <= '0;
      last_ch <= SEL_W'(NUM_CH - 1);
      step_m  <= '0;
      err     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        target[c] <= 8'(INIT_MULT);
        cur[c]    <= 8'd0;
      end
    end else begin
      if (state_nxt != state) bcnt <= '0;
      else if (state inside {LOAD_D, GAP1, LOAD_M, GAP2}) bcnt <= bcnt + 4'd1;

      dcnt <= (state == DWELL && state_nxt == DWELL) ? dcnt + 1'b1 : '0;
      tcnt <= (state_nxt == WAIT_DONE) ? tcnt + 1'b1 : '0;

      if (state == ARB && any_need) begin
        ch      <= pick;
        last_ch <= pick;
        step_m  <= step_mult(pick_tgt, pick_cur);
      end

      // Out-of-range channel indices match no entry and are dropped.
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.cmd_valid && int'(cmd_chan) == c) target[c] <= clamp_mult(bus.cmd_mult);
        if (state == WAIT_DONE && int'(ch) == c) begin
          if (done_sel) begin
            cur[c] <= step_m;
            err[c] <= 1'b0;
          end else if (timeout_hit) begin
            cur[c] <= 8'd0;
            err[c] <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/dcm_ramp_controller.md
Name: dcm_ramp_controller

Overview:
Multi-channel successor to the single-DCM reprogrammer. It holds a target multiplier per DCM_CLKGEN channel and ramps each channel's current multiplier toward that target in bounded steps. Each step is a serial PROG frame, and channels are served round-robin. Everything runs on one clock, which also drives every DCM's PROGCLK, so no clock-domain crossing exists inside. Command decode from the work-data path sits upstream and delivers single-cycle command strobes.

Parameters:
NUM_CH, 4, number of DCM channels (1..16)
CHAN_W, 2, width of cmd_chan
MIN_MULT, 2, lowest legal multiplier
MAX_MULT, 88, highest legal multiplier
INIT_MULT, 60, per-channel target after reset
DIVIDER, 8, fixed D value; D-1 is sent in the frame
STEP, 4, maximum multiplier change per frame
DWELL_CYCLES, 1024, idle cycles after each completed frame before the next arbitration
TIMEOUT_CYCLES, 65535, maximum wait for prog_done

Ports:
clk  in  1  system clock and DCM PROGCLK
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  one-cycle strobe: set the target of channel cmd_chan
cmd_chan  in  CHAN_W  channel index
cmd_mult  in  8  requested multiplier
prog_en  out  NUM_CH  per-channel PROGEN
prog_data  out  1  shared PROGDATA
prog_done  in  NUM_CH  per-channel PROGDONE (synchronised upstream)
busy  out  1  high whenever the FSM is not in IDLE
cur_mult  out  NUM_CH*8  last successfully programmed M per channel; 0 means unknown
err_timeout  out  NUM_CH  sticky per-channel timeout flag

Behaviour:
- Reset (async assert, sync release):
  - prog_en=0, prog_data=0, busy=0, err_timeout=0.
  - cur_mult=0 on every channel; every target = INIT_MULT.
  - FSM goes to IDLE; counters clear.
- Command acceptance:
  - cmd_valid is always accepted.
  - Target <= clamp(cmd_mult, MIN_MULT, MAX_MULT) on the next edge.
  - cmd_chan >= NUM_CH: command dropped, no state change.
  - A command to the channel currently mid-frame only updates its target. The running frame completes unchanged.
- Service need: channel c needs service when target[c] != cur_mult[c].
- FSM states: IDLE, ARB, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE, DWELL.
- IDLE -> ARB when any channel needs service.
- ARB (1 cycle):
  - Round-robin pick, starting at the channel after the last one served.
  - Step value: if cur=0, step M = target (direct jump, no ramp).
  - Otherwise step M = cur ± min(|target-cur|, STEP).
  - Latch channel and step M. Go to LOAD_D, or to IDLE if no channel needs service.
- Frame, prog_en driven only on the selected bit (others 0), listed as cycles of {en,data}:
  - LOAD_D: 11, 10, then 8 bits of DIVIDER-1 LSB first with en=1.
  - GAP1: 3 cycles of 00.
  - LOAD_M: 11, 11, then 8 bits of M-1 LSB first with en=1.
  - GAP2: 2 cycles of 00.
  - GO: 1 cycle of 10.
  - Total frame length is 26 cycles; first en=1 is the cycle after ARB.
- WAIT_DONE: outputs 00.
  - Count cycles and watch prog_done[ch], which must be sampled high.
  - On done: cur_mult[ch] <= step M, err_timeout[ch] <= 0, go to DWELL.
  - On count == TIMEOUT_CYCLES: err_timeout[ch] <= 1, cur_mult[ch] <= 0, go to DWELL.
  - A channel that timed out therefore retries with a direct jump to its target.
- DWELL: count DWELL_CYCLES, then go to ARB.
- Latency: a command to an idle block gives first prog_en high 2 cycles after the cmd_valid edge.
- Reset mid-frame: all outputs drop immediately and asynchronously. The aborted frame is not resumed; after release, all channels reprogram to INIT_MULT.
- prog_done on non-selected channels is ignored.
- A command changing the target while its channel dwells or waits is honoured at the next ARB.
- Each counter is sized to its parameter; no counter is allowed to wrap.

Test Plan:
- Reset release, NUM_CH=4, DWELL_CYCLES=16, done returned 5 cycles after GO:
  - Channels 0,1,2,3 are programmed once each, in order, with M-1=59 (0x3B) and D-1=7.
  - Bench checks the exact 26-cycle {en,data} sequence per frame, and cur_mult=60 on all channels afterwards.
- Ramp: after the reset sequence, cmd ch1 mult 70 with STEP=4:
  - Frames on ch1 carry M = 64, 68, 70, each separated by ≥ DWELL_CYCLES.
  - Final cur_mult[1]=70; no other channel touched.
- Clamping:
  - cmd ch2 mult 200 -> target 88.
  - cmd ch2 mult 0 -> target 2.
  - cmd_chan=5 with NUM_CH=4 -> no frame, busy stays 0.
- Round-robin fairness: targets of ch0 and ch3 changed in the same window:
  - Frames alternate ch3, ch0, ch3… per the round-robin pointer.
  - No channel gets two consecutive frames while the other still needs service.
- Timeout: hold prog_done[2]=0 with TIMEOUT_CYCLES=100:
  - err_timeout[2] sets exactly 100 cycles after GO, and cur_mult[2]=0.
  - Next frame is a direct jump to target.
  - Returning done clears err_timeout[2].
- Async reset asserted in the 5th LOAD_M cycle:
  - prog_en and prog_data read 0 with no clock edge.
  - After release, the full reset sequence of frames repeats.
